// File: rtl/hamming_sec_decoder_pipe.sv
// hamming_sec_decoder_pipe
// Two-stage pipelined Hamming single-error-correcting decoder with valid/ready
// handshakes on both sides and saturating error-event counters.
//   Stage 1: syndrome + raw codeword + valid.
//   Stage 2: correction, data extraction, status flags.
// Codeword position i (1-based) is in_cw[i-1]; parity bits sit at power-of-two
// positions, data bits fill the rest in ascending order.
// Optional macro HAMMING_DED_EN: adds an overall even-parity bit at
// in_cw[CW_W-1] and upgrades decoding to SEC-DED.
module hamming_sec_decoder_pipe #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16,
  // Smallest P with 2^P >= DATA_W+P+1, in closed form.
  localparam int P     = $clog2(DATA_W + $clog2(DATA_W + 1) + 1),
  localparam int N     = DATA_W + P,
`ifdef HAMMING_DED_EN
  localparam int CW_W  = N + 1
`else
  localparam int CW_W  = N
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [P-1:0]      out_syndrome,
  output logic              out_corrected,
  output logic              out_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corrected,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  logic              r_s1_valid;
  logic [CW_W-1:0]   r_s1_cw;
  logic [P-1:0]      r_s1_syn;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [P-1:0]      r_out_syn;
  logic              r_out_corr;
  logic              r_out_unc;

  logic [CNT_W-1:0]  r_cnt_corr;
  logic [CNT_W-1:0]  r_cnt_unc;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_out_hs;
  logic [P-1:0]      w_syn;
  logic [CW_W-1:0]   w_flip;
  logic              w_syn_nz;
  logic              w_in_range;
  logic [CW_W-1:0]   w_fix;
  logic [DATA_W-1:0] w_data;
  logic              w_corr;
  logic              w_unc;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_out_hs = r_out_valid && out_ready;
  assign in_ready = w_s1_adv;

  // Syndrome of the incoming word: bit k is the XOR of positions with index bit k set
  always_comb begin
    w_syn = '0;
    for (int i = 1; i <= N; i++) begin
      for (int k = 0; k < P; k++) begin
        if (i[k]) w_syn[k] = w_syn[k] ^ in_cw[i-1];
      end
    end
  end

  // Stage 1 register: only an accepted word loads, so idle X on in_cw never enters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_cw    <= '0;
      r_s1_syn   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_cw  <= in_cw;
        r_s1_syn <= w_syn;
      end
    end
  end

  // One-hot flip mask for the syndrome position; all-zero when clean or out of range
  always_comb begin
    w_flip = '0;
    for (int i = 1; i <= N; i++) begin
      if (int'(r_s1_syn) == i) w_flip[i-1] = 1'b1;
    end
  end

  assign w_syn_nz   = |r_s1_syn;
  assign w_in_range = |w_flip;

  // Correction decision and status flags for the word in stage 1
  always_comb begin
    w_fix  = r_s1_cw;
    w_corr = 1'b0;
    w_unc  = 1'b0;
`ifdef HAMMING_DED_EN
    if (^r_s1_cw) begin
      if (!w_syn_nz) begin
        // Only the overall parity bit was hit; data bits are already right.
        w_corr = 1'b1;
      end else if (w_in_range) begin
        w_fix  = r_s1_cw ^ w_flip;
        w_corr = 1'b1;
      end else begin
        w_unc  = 1'b1;
      end
    end else if (w_syn_nz) begin
      w_unc = 1'b1;
    end
`else
    if (w_syn_nz) begin
      if (w_in_range) begin
        w_fix  = r_s1_cw ^ w_flip;
        w_corr = 1'b1;
      end else begin
        w_unc  = 1'b1;
      end
    end
`endif
  end

  // Data bit j lives at the j-th non-power-of-two position: index = pos - #powers<=pos - 1
  for (genvar g = 1; g <= N; g++) begin : g_extract
    if ((g & (g - 1)) != 0) begin : g_data_pos
      assign w_data[g - $clog2(g + 1) - 1] = w_fix[g-1];
    end
  end

  // Stage 2 register: holds every field while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_syn   <= '0;
      r_out_corr  <= 1'b0;
      r_out_unc   <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_data;
        r_out_syn  <= r_s1_syn;
        r_out_corr <= w_corr;
        r_out_unc  <= w_unc;
      end
    end
  end

  // Saturating event counters, advanced on output handshake; clear wins
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_cnt_corr <= '0;
      r_cnt_unc  <= '0;
    end else if (w_out_hs) begin
      if (r_out_corr && (r_cnt_corr != '1)) r_cnt_corr <= r_cnt_corr + CNT_W'(1);
      if (r_out_unc && (r_cnt_unc != '1))   r_cnt_unc  <= r_cnt_unc + CNT_W'(1);
    end
  end

  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_syndrome  = r_out_syn;
  assign out_corrected = r_out_corr;
  assign out_uncorr    = r_out_unc;
  assign cnt_corrected = r_cnt_corr;
  assign cnt_uncorr    = r_cnt_unc;

endmodule

// File: tb/tb_hamming_sec_decoder_pipe.sv
// Directed bench for hamming_sec_decoder_pipe (DATA_W=4).
// dut_a uses the default counter width; dut_b uses CNT_W=2 for saturation.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_hamming_sec_decoder_pipe;
`ifdef HAMMING_DED_EN
  localparam int CW_W = 8;
  localparam logic [CW_W-1:0] CW_55 = 8'h55;
  localparam logic [CW_W-1:0] CW_7F = 8'hFF;
`else
  localparam int CW_W = 7;
  localparam logic [CW_W-1:0] CW_55 = 7'h55;
  localparam logic [CW_W-1:0] CW_7F = 7'h7F;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic            in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [CW_W-1:0] in_cw = '0;
  logic [3:0]      out_data;
  logic [2:0]      out_syndrome;
  logic            out_corrected, out_uncorr, cnt_clr = 1'b0;
  logic [15:0]     cnt_corrected, cnt_uncorr;

  logic            in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
  logic [CW_W-1:0] in_cw_b = '0;
  logic [3:0]      out_data_b;
  logic [2:0]      out_syndrome_b;
  logic            out_corrected_b, out_uncorr_b, cnt_clr_b = 1'b0;
  logic [1:0]      cnt_corrected_b, cnt_uncorr_b;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cc = 0;
  int exp_cu = 0;

  always #5 clk = ~clk;

  hamming_sec_decoder_pipe #(.DATA_W(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_syndrome(out_syndrome), .out_corrected(out_corrected), .out_uncorr(out_uncorr),
    .cnt_clr(cnt_clr), .cnt_corrected(cnt_corrected), .cnt_uncorr(cnt_uncorr)
  );

  hamming_sec_decoder_pipe #(.DATA_W(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_cw(in_cw_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_syndrome(out_syndrome_b), .out_corrected(out_corrected_b), .out_uncorr(out_uncorr_b),
    .cnt_clr(cnt_clr_b), .cnt_corrected(cnt_corrected_b), .cnt_uncorr(cnt_uncorr_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Codeword 0x55 with bit k flipped (position k+1, data 4'hB, syndrome k+1)
  function automatic logic [CW_W-1:0] flip55(input int k);
    logic [CW_W-1:0] one;
    one = CW_W'(1);
    return CW_55 ^ (one << k);
  endfunction

  // Send one word through dut_a with out_ready=1 and check latency, fields and counters
  task automatic send_word(input string tag, input logic [CW_W-1:0] cw, input logic [3:0] e_data,
                           input logic [2:0] e_syn, input logic e_corr, input logic e_unc);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_cw     = cw;
    #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_cw    = '0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(e_data));
    chk({tag, "_syn"}, 32'(out_syndrome), 32'(e_syn));
    chk({tag, "_corr"}, 32'(out_corrected), 32'(e_corr));
    chk({tag, "_unc"}, 32'(out_uncorr), 32'(e_unc));
    if (e_corr) exp_cc++;
    if (e_unc) exp_cu++;
    @(negedge clk);
    chk({tag, "_cnt_corr"}, 32'(cnt_corrected), 32'(exp_cc));
    chk({tag, "_cnt_unc"}, 32'(cnt_uncorr), 32'(exp_cu));
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int rcv;
    int flushed;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid2", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_syn", 32'(out_syndrome), 32'd0);
    chk("rst_flags", 32'({out_corrected, out_uncorr}), 32'd0);
    chk("rst_cnt", 32'({cnt_corrected, cnt_uncorr}), 32'd0);

    // Clean codewords
    send_word("clean55", CW_55, 4'hB, 3'd0, 1'b0, 1'b0);
    send_word("clean7f", CW_7F, 4'hF, 3'd0, 1'b0, 1'b0);
    send_word("clean00", '0, 4'h0, 3'd0, 1'b0, 1'b0);

    // Every single-bit flip of 0x55 within positions 1..7
    for (int p = 1; p <= 7; p++) begin
      send_word($sformatf("flip%0d", p), flip55(p - 1), 4'hB, 3'(p), 1'b1, 1'b0);
    end

`ifdef HAMMING_DED_EN
    send_word("ded_double", 8'h56, 4'hB, 3'd3, 1'b0, 1'b1);
    send_word("ded_opar", 8'hD5, 4'hB, 3'd0, 1'b1, 1'b0);
`else
    // Double error is miscorrected by plain SEC: position 3 flipped -> data 4'hA
    send_word("sec_double", 7'h56, 4'hA, 3'd3, 1'b1, 1'b0);
`endif

    // Standalone counter clear
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_cc = 0;
    exp_cu = 0;
    chk("clr_cnt_corr", 32'(cnt_corrected), 32'd0);
    chk("clr_cnt_unc", 32'(cnt_uncorr), 32'd0);

    // Backpressure: out_ready low for the first 8 cycles while 6 words are offered
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 8);
      in_valid  = (sent < 6);
      in_cw     = (sent < 6) ? flip55(sent) : '0;
      #1;
      if (cyc == 5) begin
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_queued", 32'(sent), 32'd2);
      end
      if (cyc == 5 || cyc == 7) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_syn", 32'(out_syndrome), 32'd1);
        chk("bp_hold_data", 32'(out_data), 32'hB);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("bp_order", 32'(out_syndrome), 32'(rcv + 1));
        chk("bp_data", 32'(out_data), 32'hB);
        rcv++;
        exp_cc++;
      end
    end
    in_valid = 1'b0;
    chk("bp_count", 32'(rcv), 32'd6);
    repeat (2) @(negedge clk);
    chk("bp_no_dup", 32'(out_valid), 32'd0);
    chk("bp_cnt_corr", 32'(cnt_corrected), 32'(exp_cc));

    // Saturation on the 2-bit counter instance
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid_b = 1'b1;
      in_cw_b    = flip55(k);
    end
    @(negedge clk);
    in_valid_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_cnt_corr", 32'(cnt_corrected_b), 32'd3);
    chk("sat_cnt_unc", 32'(cnt_uncorr_b), 32'd0);

    // Clear in the same cycle as a corrected handshake
    @(negedge clk);
    out_ready_b = 1'b0;
    in_valid_b  = 1'b1;
    in_cw_b     = flip55(2);
    @(negedge clk);
    in_valid_b = 1'b0;
    @(negedge clk);
    chk("clrpri_at_out", 32'(out_valid_b), 32'd1);
    out_ready_b = 1'b1;
    cnt_clr_b   = 1'b1;
    @(negedge clk);
    cnt_clr_b = 1'b0;
    chk("clrpri_cnt", 32'(cnt_corrected_b), 32'd0);

    // Reset with two words in flight
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_cw     = flip55(0);
    @(negedge clk);
    in_cw = flip55(1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("inflight_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("inflight_rst_valid", 32'(out_valid), 32'd0);
    chk("inflight_rst_fields", 32'({out_data, out_syndrome, out_corrected, out_uncorr}), 32'd0);
    chk("inflight_rst_cnt", 32'({cnt_corrected, cnt_uncorr}), 32'd0);
    @(negedge clk);
    chk("inflight_in_ready", 32'(in_ready), 32'd1);
    flushed = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) flushed++;
    end
    chk("inflight_no_flush", 32'(flushed), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/hamming_sec_decoder_pipe.md
Name: hamming_sec_decoder_pipe

Overview:
- Parametrised, pipelined Hamming single-error-correcting decoder for DATA_W data bits, with valid/ready handshakes on input and output.
- Reports the syndrome and error status per word and keeps saturating error-event counters.
- Sits between the channel/storage receive path and the data consumer.
- Generalises the fixed 7-bit/4-bit combinational decoder to arbitrary widths, with full-throughput pipelining and backpressure.

Parameters:
- DATA_W, 4, number of data bits per word; minimum 1.
- P, derived localparam, smallest integer with 2^P >= DATA_W+P+1 (4 gives 3).
- CW_W, derived localparam, DATA_W+P, or DATA_W+P+1 when HAMMING_DED_EN is defined.
- CNT_W, 16, width of each error counter.

Ports:
- clk  in  1  rising-edge clock; sole clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  decoder can accept a word this cycle.
- in_cw  in  CW_W  received codeword.
- out_valid  out  1  decoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  corrected data.
- out_syndrome  out  P  raw Hamming syndrome of the word.
- out_corrected  out  1  a single-bit error was corrected.
- out_uncorr  out  1  the error was detected but is not correctable; data is passed through uncorrected.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt_corrected  out  CNT_W  saturating count of corrected words.
- cnt_uncorr  out  CNT_W  saturating count of uncorrectable words.

Behaviour:
- Codeword layout: 1-based position i maps to in_cw[i-1]. Parity bits sit at power-of-two positions. Data bits fill the remaining positions in ascending order, with out_data[0] at the lowest data position.
- Syndrome bit k is the XOR of every position (parity bits included) whose index has bit k set.
- Stage 1 registers the syndrome, the raw codeword and a valid flag.
- Stage 2 applies correction, extracts data and registers all out_* fields and out_valid.
- Latency: 2 cycles from accepted input to out_valid, with no backpressure. Throughput is 1 word/cycle.
- Advance logic:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - A transfer occurs only when valid && ready.
- A stalled stage holds all of its fields stable. out_* must not change while out_valid=1 && out_ready=0.
- Decode (no DED):
  - Syndrome 0: clean; corrected=0, uncorr=0.
  - Syndrome s with 1 <= s <= DATA_W+P: flip position s; corrected=1.
  - Syndrome s > DATA_W+P (only possible when the code is not perfect): uncorr=1; data is not modified.
- out_corrected and out_uncorr are never both 1.
- Counters:
  - Update only on an output handshake (out_valid && out_ready).
  - Each increments by 1 per flagged word and saturates at all-ones (no wrap).
  - cnt_clr has priority over a same-cycle increment; the result is 0.
- Reset:
  - Applies to in-flight words: both stage valids clear and queued words are discarded.
  - Reset values: out_valid=0, out_data=0, out_syndrome=0, out_corrected=0, out_uncorr=0, both counters=0.
  - in_ready=1 in the first cycle after reset deasserts.
- X on in_cw while in_valid=0 must not propagate into the counters or out_valid.

Optional Feature:
- Macro: HAMMING_DED_EN.
- Defined:
  - in_cw[CW_W-1] is an overall even-parity bit over all other codeword bits.
  - Let pe = XOR of all CW_W bits.
  - Syndrome 0 and pe=0: clean.
  - Syndrome 0 and pe=1: error in the overall parity bit; corrected=1, data unchanged.
  - Syndrome nonzero and pe=1: single error; correct as above, or uncorr=1 if s is out of range.
  - Syndrome nonzero and pe=0: double error; uncorr=1, data passed raw.
- Not defined: CW_W=DATA_W+P, and decode is plain SEC as above.

Test Plan:
- DATA_W=4, no DED, in_cw=7'h55 -> two cycles later out_data=4'hB, syndrome=0, corrected=0, uncorr=0.
- Each single-bit flip of 7'h55 (e.g. 7'h45, position 5) -> out_data=4'hB, syndrome equals the flipped position, corrected=1, cnt_corrected increments by 1 per word.
- HAMMING_DED_EN, in_cw=8'h56 (bits 0 and 1 flipped from 8'h55) -> syndrome=3, uncorr=1, out_data=raw data bits, cnt_uncorr=1. Separately, 8'hD5 -> corrected=1, out_data=4'hB.
- Stream 6 words back-to-back while out_ready is held low from cycle 2 -> in_ready drops after 2 words are queued, output is held stable, and all 6 words emerge in order with no loss or duplication once out_ready=1.
- CNT_W=2, 5 corrected words -> cnt_corrected=3 (saturated). cnt_clr asserted in the same cycle as a corrected handshake -> 0.
- Assert rst for 1 cycle with 2 words in flight -> out_valid=0, counters=0 next cycle, and no flushed word ever appears at the output.
